seg_bcd_loader: RTL and testbench

- Sequencing controller that feeds the 6-digit dynamic seven-segment scanner.
- Accepts a 20-bit unsigned binary value through a valid/ready handshake.
- Converts the value to six BCD digits with a serial shift-add-3 (double-dabble) engine.
- Applies leading-zero blanking and overflow indication, then commits all six digit codes atomically to the scanner's dis1..dis6 inputs.

---
 rtl/seg_bcd_if.sv | 13 +
 rtl/seg_bcd_loader.sv | 146 ++++++++++++++
 tb/tb_seg_bcd_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_bcd_if.sv
// seg_bcd_if: value-load handshake between a producer and seg_bcd_loader.
//   in_valid : producer presents in_data this cycle
//   in_data  : 20-bit unsigned binary value to display
//   in_ready : loader is idle and will take in_valid/in_data on the next edge
// master = producer side, slave = loader side.
interface seg_bcd_if;
  logic        in_valid;
  logic [19:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seg_bcd_loader.sv
// seg_bcd_loader: takes a 20-bit binary value over a valid/ready handshake,
// converts it to six BCD digits with a serial double-dabble engine (one
// bit per clock), applies overflow / leading-zero shaping and then commits
// all six digit codes at once to the scanner inputs dis1..dis6.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_bcd_if.slave (in_valid, in_data, in_ready)
//   disp_en    : 1 = show committed digits, 0 = show blanks (code 11)
//   done       : one-cycle pulse on the cycle new digits appear
//   dis1..dis6 : digit codes, dis1 most significant; 0-9, 10 = '-', 11 = blank
module seg_bcd_loader #(
  parameter bit          LZ_BLANK = 1'b1,
  parameter logic [19:0] MAX_VAL  = 20'd999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_bcd_if.slave   bus,
  input  logic       disp_en,
  output logic       done,
  output logic [3:0] dis1,
  output logic [3:0] dis2,
  output logic [3:0] dis3,
  output logic [3:0] dis4,
  output logic [3:0] dis5,
  output logic [3:0] dis6
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [23:0] ALL_BLANK = {6{4'hB}};
  localparam logic [23:0] ALL_DASH  = {6{4'hA}};

  logic [1:0]  state;
  logic        in_ready_q;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [4:0]  cnt;
  logic        ovf;
  logic [23:0] committed;
  logic [23:0] dis_q;

  logic        accept;
  logic [23:0] final_digits;
  logic [23:0] shown;

  // Double-dabble correction step: every nibble >= 5 gets +3 before the shift.
  function automatic logic [23:0] add3(input logic [23:0] b);
    logic [23:0] r;
    logic [3:0]  nib;
    r = b;
    for (int i = 0; i < 6; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

  // Overflow pattern, or leading-zero blanking from dis1 toward dis5.
  // The rightmost digit is never blanked so that zero still shows "0".
  function automatic logic [23:0] shape(input logic [23:0] b, input logic of);
    logic [23:0] r;
    logic        lead;
    r    = b;
    lead = 1'b1;
    if (of) begin
      r = ALL_DASH;
    end else if (LZ_BLANK) begin
      for (int i = 0; i < 5; i++) begin
        if (lead && r[23-4*i -: 4] == 4'd0) r[23-4*i -: 4] = 4'hB;
        else                                 lead = 1'b0;
      end
    end
    return r;
  endfunction

  // in_ready is a register: it drops on the accept edge and comes back one
  // edge after the commit, so a new value is never taken on the commit's
  // heels.
  assign accept       = (state == IDLE) && in_ready_q && bus.in_valid;
  assign final_digits = shape(bcd, ovf);

  // NOTE: every signal driven from always_comb gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shown = committed;
    if (state == COMMIT) shown = final_digits;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      done       <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      // NOTE: the committed-digit store is only six nibbles of flops, so it
      // is reset to blanks like everything else rather than left unknown.
      committed  <= ALL_BLANK;
      dis_q      <= ALL_BLANK;
    end else begin
      done       <= 1'b0;
      in_ready_q <= (state == IDLE) && !accept;
      dis_q      <= disp_en ? shown : ALL_BLANK;

      case (state)
        IDLE: begin
          if (accept) begin
            bin   <= bus.in_data;
            bcd   <= '0;
            cnt   <= '0;
            ovf   <= (bus.in_data > MAX_VAL);
            state <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {add3(bcd), bin} << 1;
          cnt        <= cnt + 5'd1;
          if (cnt == 5'd19) state <= COMMIT;
        end
        COMMIT: begin
          committed <= final_digits;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign dis1 = dis_q[23:20];
  assign dis2 = dis_q[19:16];
  assign dis3 = dis_q[15:12];
  assign dis4 = dis_q[11:8];
  assign dis5 = dis_q[7:4];
  assign dis6 = dis_q[3:0];

endmodule

// File: tb/tb_seg_bcd_loader.sv
// tb_seg_bcd_loader: drives one LZ_BLANK=1 and one LZ_BLANK=0 loader with
// identical stimulus and compares both against a cycle-level behavioural
// model (decimal arithmetic plus an accept-time window), plus directed
// literal expectations for the documented display patterns.
module tb_seg_bcd_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = '0;
  logic        disp_en = 1'b1;

  logic       done1, done0;
  logic [3:0] a1, a2, a3, a4, a5, a6;
  logic [3:0] b1, b2, b3, b4, b5, b6;

  seg_bcd_if if1 ();
  seg_bcd_if if0 ();

  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;

  seg_bcd_loader #(.LZ_BLANK(1'b1), .MAX_VAL(20'd999_999)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .disp_en(disp_en), .done(done1),
    .dis1(a1), .dis2(a2), .dis3(a3), .dis4(a4), .dis5(a5), .dis6(a6)
  );

  seg_bcd_loader #(.LZ_BLANK(1'b0), .MAX_VAL(20'd999_999)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .disp_en(disp_en), .done(done0),
    .dis1(b1), .dis2(b2), .dis3(b3), .dis4(b4), .dis5(b5), .dis6(b6)
  );

  wire [23:0] d1 = {a1, a2, a3, a4, a5, a6};
  wire [23:0] d0 = {b1, b2, b3, b4, b5, b6};

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [23:0] BLANK6 = 24'hBBBBBB;

  function automatic logic [23:0] model_digits(input int unsigned v, input bit lz);
    int          d[6];
    int          p[6] = '{100000, 10000, 1000, 100, 10, 1};
    bit          lead;
    logic [23:0] r;
    if (v > 999999) return 24'hAAAAAA;
    for (int i = 0; i < 6; i++) d[i] = (v / p[i]) % 10;
    lead = lz;
    for (int i = 0; i < 5; i++) begin
      if (lead && d[i] == 0) d[i] = 11;
      else                   lead = 1'b0;
    end
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[19:0], 4'(d[i])};
    return r;
  endfunction

  int          cyc = 0;
  int          acc_edge = -1;
  int unsigned acc_val = 0;
  bit          m_ready = 1'b1;
  bit          m_done = 1'b0;
  logic [23:0] com1 = BLANK6, com0 = BLANK6;
  logic [23:0] m_dis1 = BLANK6, m_dis0 = BLANK6;

  // A value accepted on edge k makes the block busy through edge k+21 and
  // publishes its digits on edge k+21; displayed codes follow disp_en.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; acc_edge = -1; m_ready = 1'b1; m_done = 1'b0;
        com1 = BLANK6; com0 = BLANK6; m_dis1 = BLANK6; m_dis0 = BLANK6;
      end else begin
        cyc++;
        if (m_ready && in_valid) begin
          acc_edge = cyc;
          acc_val  = in_data;
        end
        m_done = (acc_edge >= 0) && (cyc == acc_edge + 21);
        if (m_done) begin
          com1 = model_digits(acc_val, 1'b1);
          com0 = model_digits(acc_val, 1'b0);
        end
        m_ready = !((acc_edge >= 0) && (cyc >= acc_edge) && (cyc <= acc_edge + 21));
        m_dis1  = disp_en ? com1 : BLANK6;
        m_dis0  = disp_en ? com0 : BLANK6;
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("ready_lz1", 32'(if1.in_ready), 32'(m_ready));
        check("ready_lz0", 32'(if0.in_ready), 32'(m_ready));
        check("done_lz1",  32'(done1), 32'(m_done));
        check("done_lz0",  32'(done0), 32'(m_done));
        check("dis_lz1",   32'(d1), 32'(m_dis1));
        check("dis_lz0",   32'(d0), 32'(m_dis0));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge: waits for in_ready, then presents v for one cycle.
  task automatic load(input logic [19:0] v);
    for (int i = 0; i < 60 && !if1.in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges until done is seen (sampled #1 after each posedge).
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        n = i;
        break;
      end
    end
    if (n < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_check(input logic [19:0] v, input logic [23:0] e1, input logic [23:0] e0);
    int n;
    @(negedge clk);
    load(v);
    wait_done(n);
    check("latency", 32'(n), 32'd21);
    check("lit_lz1", 32'(d1), 32'(e1));
    check("lit_lz0", 32'(d0), 32'(e0));
  endtask

  initial begin
    int          n;
    logic [19:0] v;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_dis_lz1", 32'(d1), 32'(BLANK6));
    check("rst_dis_lz0", 32'(d0), 32'(BLANK6));
    check("rst_ready",   32'(if1.in_ready), 32'd1);
    check("rst_done",    32'(done1), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed patterns.
    load_check(20'd123456,  24'h123456, 24'h123456);
    load_check(20'd0,       24'hBBBBB0, 24'h000000);
    load_check(20'd407,     24'hBBB407, 24'h000407);
    load_check(20'd999999,  24'h999999, 24'h999999);
    load_check(20'd1000000, 24'hAAAAAA, 24'hAAAAAA);
    load_check(20'hFFFFF,   24'hAAAAAA, 24'hAAAAAA);

    // A second value presented during conversion is ignored.
    @(negedge clk);
    load(20'd555555);
    repeat (5) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 20'd42;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    wait_done(n);
    check("ignored_lz1", 32'(d1), 32'h555555);
    repeat (3) @(negedge clk);
    check("hold_lz1", 32'(d1), 32'h555555);
    load_check(20'd42, 24'hBBBB42, 24'h000042);

    // disp_en low: commit happens internally, shows once re-enabled.
    @(negedge clk);
    disp_en = 1'b0;
    load(20'd314159);
    wait_done(n);
    check("dis_off_lz1", 32'(d1), 32'(BLANK6));
    @(negedge clk);
    disp_en = 1'b1;
    @(posedge clk);
    #1;
    check("dis_on_lz1", 32'(d1), 32'h314159);
    check("dis_on_lz0", 32'(d0), 32'h314159);

    // Randomised loads with noise on in_valid while busy.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 20'($urandom);
        1:       v = 20'($urandom_range(0, 999));
        2:       v = 20'($urandom_range(999990, 1000010));
        default: v = 20'($urandom_range(0, 999999));
      endcase
      @(negedge clk);
      disp_en = ($urandom_range(0, 4) != 0);
      load(v);
      for (int j = 0; j < 18; j++) begin
        in_valid = ($urandom_range(0, 3) == 0);
        in_data  = 20'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      wait_done(n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    disp_en = 1'b1;
    load(20'd777777);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dis_lz1", 32'(d1), 32'(BLANK6));
    check("midrst_dis_lz0", 32'(d0), 32'(BLANK6));
    check("midrst_ready",   32'(if1.in_ready), 32'd1);
    check("midrst_done",    32'(done1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_dis", 32'(d1), 32'(BLANK6));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
